// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T-state sequencer for the Bat Amateur CPU.
// A 4-bit step counter walks through the shared fetch steps (T0-T3) and the
// opcode-specific execute steps, and every control strobe is a combinational
// decode of the current step, the opcode and the flags.
module control_sequencer #(
  parameter int BUS_WIDTH         = 16,
  parameter bit HALT_ON_UNDEFINED = 1'b0
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [BUS_WIDTH-1:0] INSTRUCTION,
  input  logic                 CARRY_FLAG,
  input  logic                 ZERO_FLAG,
  output logic                 PC_COUNT,
  output logic                 PC_ENABLE,
  output logic                 PC_LOAD,
  output logic                 MAR_LOAD,
  output logic                 RAM_ENABLE,
  output logic                 RAM_LOAD,
  output logic                 IR_LOAD,
  output logic                 IR_ENABLE,
  output logic                 A_LOAD,
  output logic                 A_ENABLE,
  output logic                 B_LOAD,
  output logic                 ALU_ENABLE,
  output logic                 ALU_SUB,
  output logic                 FLAGS_LOAD,
  output logic                 OUT_LOAD,
  output logic                 HALT,
  output logic [3:0]           STEP
);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDA = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_STA = 4'd4,
    OP_LDI = 4'd5,
    OP_JMP = 4'd6,
    OP_JC  = 4'd7,
    OP_JZ  = 4'd8,
    OP_OUT = 4'd14,
    OP_HLT = 4'd15
  } opcode_t;

  logic [3:0] step_q;
  logic       halted_q;
  logic [3:0] raw_op;
  opcode_t    eff_op;
  logic       jump_taken;
  logic [3:0] last_step;
  logic       unused_operand;

  // The operand bits only travel over the bus through the IR; the sequencer ignores them.
  assign unused_operand = ^INSTRUCTION[BUS_WIDTH-5:0];

  assign raw_op = INSTRUCTION[BUS_WIDTH-1 -: 4];
  assign STEP   = step_q;
  assign HALT   = halted_q;

  // Fold the undefined opcodes onto NOP or HLT so the rest of the decode only sees defined ones.
  always_comb begin
    eff_op = OP_NOP;
    case (raw_op)
      4'd9, 4'd10, 4'd11, 4'd12, 4'd13: eff_op = HALT_ON_UNDEFINED ? OP_HLT : OP_NOP;
      default:                          eff_op = opcode_t'(raw_op);
    endcase
  end

  // Work out the final step of the current instruction; conditional jumps stop at T4 when not taken.
  always_comb begin
    jump_taken = ((eff_op == OP_JC) && CARRY_FLAG) || ((eff_op == OP_JZ) && ZERO_FLAG);
    last_step  = 4'd3;
    case (eff_op)
      OP_LDA, OP_STA:         last_step = 4'd7;
      OP_ADD, OP_SUB:         last_step = 4'd9;
      OP_LDI, OP_JMP, OP_OUT: last_step = 4'd5;
      OP_JC, OP_JZ:           last_step = jump_taken ? 4'd5 : 4'd4;
      OP_HLT:                 last_step = 4'd4;
      default:                last_step = 4'd3;
    endcase
  end

  // Advance the step counter, wrap after the last step, and latch the halted state at HLT's T4.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      step_q   <= 4'd0;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      if ((step_q == 4'd4) && (eff_op == OP_HLT)) begin
        halted_q <= 1'b1;
      end else if (step_q >= last_step) begin
        step_q <= 4'd0;
      end else begin
        step_q <= step_q + 4'd1;
      end
    end
  end

  // Decode the strobes for the current step; everything is forced low in reset and once halted.
  always_comb begin
    PC_COUNT   = 1'b0;
    PC_ENABLE  = 1'b0;
    PC_LOAD    = 1'b0;
    MAR_LOAD   = 1'b0;
    RAM_ENABLE = 1'b0;
    RAM_LOAD   = 1'b0;
    IR_LOAD    = 1'b0;
    IR_ENABLE  = 1'b0;
    A_LOAD     = 1'b0;
    A_ENABLE   = 1'b0;
    B_LOAD     = 1'b0;
    ALU_ENABLE = 1'b0;
    ALU_SUB    = 1'b0;
    FLAGS_LOAD = 1'b0;
    OUT_LOAD   = 1'b0;
    if (!RESET && !halted_q) begin
      case (step_q)
        4'd0: PC_ENABLE = 1'b1;
        4'd1: begin
          PC_ENABLE = 1'b1;
          MAR_LOAD  = 1'b1;
        end
        4'd2: RAM_ENABLE = 1'b1;
        4'd3: begin
          RAM_ENABLE = 1'b1;
          IR_LOAD    = 1'b1;
          PC_COUNT   = 1'b1;
        end
        4'd4: begin
          case (eff_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP: IR_ENABLE = 1'b1;
            OP_JC, OP_JZ:                                   IR_ENABLE = jump_taken;
            OP_OUT:                                         A_ENABLE  = 1'b1;
            default: ;
          endcase
        end
        4'd5: begin
          case (eff_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              IR_ENABLE = 1'b1;
              MAR_LOAD  = 1'b1;
            end
            OP_LDI: begin
              IR_ENABLE = 1'b1;
              A_LOAD    = 1'b1;
            end
            OP_JMP, OP_JC, OP_JZ: begin
              IR_ENABLE = 1'b1;
              PC_LOAD   = 1'b1;
            end
            OP_OUT: begin
              A_ENABLE = 1'b1;
              OUT_LOAD = 1'b1;
            end
            default: ;
          endcase
        end
        4'd6: begin
          case (eff_op)
            OP_LDA, OP_ADD, OP_SUB: RAM_ENABLE = 1'b1;
            OP_STA:                 A_ENABLE   = 1'b1;
            default: ;
          endcase
        end
        4'd7: begin
          case (eff_op)
            OP_LDA: begin
              RAM_ENABLE = 1'b1;
              A_LOAD     = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              RAM_ENABLE = 1'b1;
              B_LOAD     = 1'b1;
            end
            OP_STA: begin
              A_ENABLE = 1'b1;
              RAM_LOAD = 1'b1;
            end
            default: ;
          endcase
        end
        4'd8: begin
          if ((eff_op == OP_ADD) || (eff_op == OP_SUB)) begin
            ALU_ENABLE = 1'b1;
            ALU_SUB    = (eff_op == OP_SUB);
          end
        end
        4'd9: begin
          if ((eff_op == OP_ADD) || (eff_op == OP_SUB)) begin
            ALU_ENABLE = 1'b1;
            A_LOAD     = 1'b1;
            FLAGS_LOAD = 1'b1;
            ALU_SUB    = (eff_op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks of control_sequencer
// against a micro-program table model of the instruction set.
module tb_control_sequencer;

  // Strobe vector bit masks, in the packing order used for both DUT instances.
  localparam logic [14:0] PCC  = 15'h4000;
  localparam logic [14:0] PCE  = 15'h2000;
  localparam logic [14:0] PCL  = 15'h1000;
  localparam logic [14:0] MARL = 15'h0800;
  localparam logic [14:0] RAME = 15'h0400;
  localparam logic [14:0] RAML = 15'h0200;
  localparam logic [14:0] IRL  = 15'h0100;
  localparam logic [14:0] IRE  = 15'h0080;
  localparam logic [14:0] AL   = 15'h0040;
  localparam logic [14:0] AE   = 15'h0020;
  localparam logic [14:0] BL   = 15'h0010;
  localparam logic [14:0] ALUE = 15'h0008;
  localparam logic [14:0] SUBS = 15'h0004;
  localparam logic [14:0] FL   = 15'h0002;
  localparam logic [14:0] OUTL = 15'h0001;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        carryFlag = 1'b0;
  logic        zeroFlag = 1'b0;

  wire  [14:0] str0;
  wire  [14:0] str1;
  wire         halt0;
  wire         halt1;
  wire  [3:0]  step0;
  wire  [3:0]  step1;

  bit          sel = 1'b0;
  int          total = 0;
  int          bad = 0;

  logic [14:0] expSeq[$];
  bit          expHalts;

  logic [14:0] obsStr;
  logic        obsHalt;
  logic [3:0]  obsStep;

  assign obsStr  = sel ? str1 : str0;
  assign obsHalt = sel ? halt1 : halt0;
  assign obsStep = sel ? step1 : step0;

  always #5 clock = ~clock;

  control_sequencer #(.BUS_WIDTH(16), .HALT_ON_UNDEFINED(1'b0)) dut0 (
    .CLOCK(clock), .RESET(reset), .INSTRUCTION(instruction),
    .CARRY_FLAG(carryFlag), .ZERO_FLAG(zeroFlag),
    .PC_COUNT(str0[14]), .PC_ENABLE(str0[13]), .PC_LOAD(str0[12]), .MAR_LOAD(str0[11]),
    .RAM_ENABLE(str0[10]), .RAM_LOAD(str0[9]), .IR_LOAD(str0[8]), .IR_ENABLE(str0[7]),
    .A_LOAD(str0[6]), .A_ENABLE(str0[5]), .B_LOAD(str0[4]), .ALU_ENABLE(str0[3]),
    .ALU_SUB(str0[2]), .FLAGS_LOAD(str0[1]), .OUT_LOAD(str0[0]),
    .HALT(halt0), .STEP(step0)
  );

  control_sequencer #(.BUS_WIDTH(16), .HALT_ON_UNDEFINED(1'b1)) dut1 (
    .CLOCK(clock), .RESET(reset), .INSTRUCTION(instruction),
    .CARRY_FLAG(carryFlag), .ZERO_FLAG(zeroFlag),
    .PC_COUNT(str1[14]), .PC_ENABLE(str1[13]), .PC_LOAD(str1[12]), .MAR_LOAD(str1[11]),
    .RAM_ENABLE(str1[10]), .RAM_LOAD(str1[9]), .IR_LOAD(str1[8]), .IR_ENABLE(str1[7]),
    .A_LOAD(str1[6]), .A_ENABLE(str1[5]), .B_LOAD(str1[4]), .ALU_ENABLE(str1[3]),
    .ALU_SUB(str1[2]), .FLAGS_LOAD(str1[1]), .OUT_LOAD(str1[0]),
    .HALT(halt1), .STEP(step1)
  );

  // One comparison: count it, and report tag/observed/expected when it differs.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, observed, expected);
    end
  endtask

  // Reference model: the complete micro-program (one strobe word per T-state) of an instruction.
  task automatic buildModel(input logic [3:0] op, input bit c, input bit z, input bit haltOnUndef);
    expSeq.delete();
    expHalts = 1'b0;
    expSeq.push_back(PCE);
    expSeq.push_back(PCE | MARL);
    expSeq.push_back(RAME);
    expSeq.push_back(RAME | IRL | PCC);
    case (op)
      4'd1: begin
        expSeq.push_back(IRE); expSeq.push_back(IRE | MARL);
        expSeq.push_back(RAME); expSeq.push_back(RAME | AL);
      end
      4'd2, 4'd3: begin
        expSeq.push_back(IRE); expSeq.push_back(IRE | MARL);
        expSeq.push_back(RAME); expSeq.push_back(RAME | BL);
        expSeq.push_back(ALUE | ((op == 4'd3) ? SUBS : 15'h0));
        expSeq.push_back(ALUE | AL | FL | ((op == 4'd3) ? SUBS : 15'h0));
      end
      4'd4: begin
        expSeq.push_back(IRE); expSeq.push_back(IRE | MARL);
        expSeq.push_back(AE); expSeq.push_back(AE | RAML);
      end
      4'd5: begin expSeq.push_back(IRE); expSeq.push_back(IRE | AL); end
      4'd6: begin expSeq.push_back(IRE); expSeq.push_back(IRE | PCL); end
      4'd7, 4'd8: begin
        if ((op == 4'd7) ? c : z) begin
          expSeq.push_back(IRE); expSeq.push_back(IRE | PCL);
        end else begin
          expSeq.push_back(15'h0);
        end
      end
      4'd14: begin expSeq.push_back(AE); expSeq.push_back(AE | OUTL); end
      4'd15: begin expSeq.push_back(15'h0); expHalts = 1'b1; end
      4'd9, 4'd10, 4'd11, 4'd12, 4'd13: begin
        if (haltOnUndef) begin
          expSeq.push_back(15'h0); expHalts = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  // Assert reset for a cycle, check the reset state, and release just after a rising edge.
  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("reset_step", {12'h0, obsStep}, 16'h0);
    checkOutput("reset_strobes", {1'b0, obsStr}, 16'h0);
    checkOutput("reset_halt", {15'h0, obsHalt}, 16'h0);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Drive one instruction starting at T0 and check every step against the model, plus the halted tail.
  task automatic applyStimulus(input logic [15:0] instr, input bit c, input bit z);
    buildModel(instr[15:12], c, z, sel);
    for (int i = 0; i < expSeq.size(); i++) begin
      @(negedge clock);
      if (i == 0) begin
        instruction = instr;
        carryFlag   = c;
        zeroFlag    = z;
      end
      #1;
      checkOutput($sformatf("step_%h_T%0d", instr, i), {12'h0, obsStep}, 16'(i));
      checkOutput($sformatf("strobes_%h_T%0d", instr, i), {1'b0, obsStr}, {1'b0, expSeq[i]});
      checkOutput($sformatf("halt_%h_T%0d", instr, i), {15'h0, obsHalt}, 16'h0);
    end
    if (expHalts) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        #1;
        checkOutput("halted_step", {12'h0, obsStep}, 16'd4);
        checkOutput("halted_strobes", {1'b0, obsStr}, 16'h0);
        checkOutput("halted_halt", {15'h0, obsHalt}, 16'h1);
      end
    end
  endtask

  // Safety net so the run always ends even if something stalls.
  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence followed by randomized instructions.
  initial begin
    logic [3:0] op;
    doReset();

    // Back-to-back NOPs right after reset.
    applyStimulus(16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);

    // ALU instructions.
    applyStimulus(16'h2034, 1'b0, 1'b0);
    applyStimulus(16'h3034, 1'b0, 1'b0);

    // Conditional jumps, both outcomes.
    applyStimulus(16'h8010, 1'b0, 1'b0);
    applyStimulus(16'h8010, 1'b0, 1'b1);
    applyStimulus(16'h7010, 1'b1, 1'b0);
    applyStimulus(16'h7010, 1'b0, 1'b1);

    // Remaining defined instructions.
    applyStimulus(16'h1005, 1'b0, 1'b0);
    applyStimulus(16'h4007, 1'b0, 1'b0);
    applyStimulus(16'h5123, 1'b0, 1'b0);
    applyStimulus(16'h6042, 1'b0, 1'b0);
    applyStimulus(16'hE000, 1'b0, 1'b0);

    // HLT holds for 20 cycles, then reset clears it.
    applyStimulus(16'hF000, 1'b0, 1'b0);
    doReset();

    // Reset pulsed in the middle of LDA's T7.
    buildModel(4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) instruction = 16'h1005;
      #1;
      checkOutput($sformatf("lda_cut_T%0d", i), {1'b0, obsStr}, {1'b0, expSeq[i]});
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_strobes", {1'b0, obsStr}, 16'h0);
    checkOutput("midreset_step", {12'h0, obsStep}, 16'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(16'h1005, 1'b0, 1'b0);

    // Undefined opcode: NOP on the default instance, HLT on the halting one.
    doReset();
    sel = 1'b0;
    applyStimulus(16'hA000, 1'b0, 1'b0);
    applyStimulus(16'hA000, 1'b0, 1'b0);
    doReset();
    sel = 1'b1;
    applyStimulus(16'hA000, 1'b0, 1'b0);
    doReset();
    sel = 1'b0;

    // Randomized instruction stream on the default instance.
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      applyStimulus({op, 12'($urandom)}, 1'($urandom), 1'($urandom));
      if (op == 4'd15) doReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the Bat Amateur CPU. It reads the 16-bit word held in the instruction register and steps a T-state counter through fetch and execute micro-steps. Each step drives the LOAD, ENABLE and COUNT strobes of the PC, MAR, RAM, IR, A, B, ALU and output registers. Bus sources register their outputs, so every bus transfer takes two steps: a drive step (source ENABLE) and a latch step (source ENABLE held, sink LOAD).

## Interface
- BUS_WIDTH, 16, instruction width; opcode = INSTRUCTION[BUS_WIDTH-1:BUS_WIDTH-4].
- HALT_ON_UNDEFINED, 0, 1 = undefined opcodes halt; 0 = undefined opcodes act as NOP.

- CLOCK  in  1  sole clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- INSTRUCTION  in  BUS_WIDTH  current instruction-register contents.
- CARRY_FLAG, ZERO_FLAG  in  1 each  flags-register outputs.
- PC_COUNT, PC_ENABLE, PC_LOAD  out  1 each  program counter strobes.
- MAR_LOAD  out  1  memory address register load.
- RAM_ENABLE, RAM_LOAD  out  1 each  memory drive and write.
- IR_LOAD, IR_ENABLE  out  1 each  instruction register strobes; IR_ENABLE places the 12-bit operand on the bus.
- A_LOAD, A_ENABLE, B_LOAD  out  1 each  accumulator and B register strobes.
- ALU_ENABLE, ALU_SUB, FLAGS_LOAD  out  1 each  ALU drive, subtract select, flags latch.
- OUT_LOAD  out  1  output register load.
- HALT  out  1  high once HLT has executed.
- STEP  out  4  current T-state (debug).

## Operation
- State: 4-bit step counter STEP (0..9) plus a HALTED bit.
- Control outputs are combinational decodes of STEP, opcode and the flags. All control outputs read 0 while RESET is high.
- Fetch, common to all instructions:
  - T0: PC_ENABLE.
  - T1: PC_ENABLE, MAR_LOAD.
  - T2: RAM_ENABLE.
  - T3: RAM_ENABLE, IR_LOAD, PC_COUNT.
- Execute steps (opcode is valid from T4):
  - 0 NOP: ends after T3.
  - 1 LDA: T4 IR_ENABLE; T5 IR_ENABLE+MAR_LOAD; T6 RAM_ENABLE; T7 RAM_ENABLE+A_LOAD.
  - 2 ADD / 3 SUB: T4–T6 as LDA; T7 RAM_ENABLE+B_LOAD; T8 ALU_ENABLE; T9 ALU_ENABLE+A_LOAD+FLAGS_LOAD. ALU_SUB is high in T8–T9 for SUB only.
  - 4 STA: T4 IR_ENABLE; T5 IR_ENABLE+MAR_LOAD; T6 A_ENABLE; T7 A_ENABLE+RAM_LOAD.
  - 5 LDI: T4 IR_ENABLE; T5 IR_ENABLE+A_LOAD.
  - 6 JMP: T4 IR_ENABLE; T5 IR_ENABLE+PC_LOAD.
  - 7 JC / 8 JZ: CARRY_FLAG / ZERO_FLAG is sampled in T4.
    - Flag set: same steps as JMP.
    - Flag clear: no strobes in T4; instruction ends at T4.
  - 14 OUT: T4 A_ENABLE; T5 A_ENABLE+OUT_LOAD.
  - 15 HLT: T4 asserts no strobes; HALTED is set at the end of T4.
  - 9–13 (undefined): handled as NOP; with HALT_ON_UNDEFINED=1, handled as HLT.
- Instruction end: on the clock after the instruction's last step, STEP returns to 0. No idle steps are inserted.
- Halted:
  - STEP freezes at its current value and all strobes are 0.
  - HALT=1 until RESET.
- Each step asserts at most one bus ENABLE; this is guaranteed by construction.

## Timing
- Reset (asynchronous): STEP=0, HALTED=0, HALT=0, all strobes 0.
- First fetch: T0 is the first full cycle after RESET deasserts.
- IR_LOAD in T3: the new instruction is visible on INSTRUCTION during T4.
- Instruction lengths: NOP 4 cycles; LDI/JMP/OUT/taken JC-JZ 6; LDA/STA 8; ADD/SUB 10; untaken JC/JZ 5.
- Reset mid-instruction: all strobes drop immediately and STEP=0. No partial transfer completes after reset asserts.
- Flags are sampled combinationally in T4; the flags register must be stable before T4. It is, since FLAGS_LOAD occurs at the latest in T9 of the previous instruction.

## Test plan
- Reset release, INSTRUCTION=0x0000 → PC_ENABLE in T0; PC_ENABLE+MAR_LOAD in T1; RAM_ENABLE+IR_LOAD+PC_COUNT in T3; STEP 0,1,2,3,0 repeating.
- INSTRUCTION=0x2034 (ADD) → MAR_LOAD in T5, B_LOAD in T7, A_LOAD+FLAGS_LOAD in T9, ALU_SUB=0; STEP=0 on the 11th cycle. With 0x3034 the sequence is identical but ALU_SUB=1 in T8–T9.
- INSTRUCTION=0x8010 (JZ):
  - ZERO_FLAG=0 → no PC_LOAD; STEP goes 4→0.
  - ZERO_FLAG=1 → PC_LOAD in T5.
- INSTRUCTION=0xF000 (HLT) → HALT=1 after T4; no strobes for 20 cycles; RESET → HALT=0, STEP=0.
- RESET pulsed mid-cycle during T7 of LDA (0x1005) → A_LOAD drops immediately; fetch restarts at T0.
- HALT_ON_UNDEFINED=0 vs 1 with INSTRUCTION=0xA000 → 4-cycle NOP vs HALT=1 after T4.
